mvm_seq_ctrl: RTL
=================

// Module: mvm_seq_ctrl
// PURPOSE
//  Parametrised sequencer for the MVM engine. It streams vector/matrix read addresses over
//  R output rows of N words each, one beat per cycle, for rows_per_olane (R) rows per lane.
//  It marks accumulator boundaries, aligned to memory read latency, for downstream MAC lanes.
//  Adds stall, abort, done, zero-size handling and explicit address wrap.
//  Sits between the host start/config interface and the vector/matrix RAMs plus MAC lanes.
// PARAMETERS
//  VEC_ADDRW  8              vector RAM address width
//  MAT_ADDRW  9              matrix RAM address width
//  VEC_SIZEW  VEC_ADDRW+1    width of vec_num_words (N)
//  MAT_SIZEW  MAT_ADDRW+1    width of mat_num_rows_per_olane (R)
//  RD_LAT     1              RAM read latency in cycles (>=0); accum_*/ovalid delay vs address
// PORTS
//  clk                     in   1          clock
//  rst                     in   1          reset: synchronous, active-high
//  start                   in   1          request a run; sampled only in IDLE
//  abort                   in   1          cancel a run in progress
//  stall                   in   1          hold the issue counters this cycle
//  vec_start_addr          in   VEC_ADDRW  first vector word address
//  vec_num_words           in   VEC_SIZEW  N, words per row
//  mat_start_addr          in   MAT_ADDRW  first matrix word address
//  mat_num_rows_per_olane  in   MAT_SIZEW  R, rows per output lane
//  vec_raddr               out  VEC_ADDRW  vector read address (registered)
//  mat_raddr               out  MAT_ADDRW  matrix read address (registered)
//  rd_en                   out  1          addresses valid this cycle
//  accum_first             out  1          beat is word 0 of a row (delayed by RD_LAT)
//  accum_last              out  1          beat is word N-1 of a row (delayed by RD_LAT)
//  ovalid                  out  1          read data beat valid at MAC input (delayed by RD_LAT)
//  busy                    out  1          run in progress
//  done                    out  1          one-cycle pulse at normal completion
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; counters and delay pipeline cleared.
//  FSM states: IDLE, ISSUE, DRAIN.
//  IDLE:
//   - start=1 latches all config inputs.
//   - If N==0 or R==0: no reads, done=1 next cycle, stay IDLE.
//   - Otherwise go to ISSUE. The first rd_en appears the cycle after start is sampled.
//  ISSUE: counters w (0..N-1), r (0..R-1), m (running matrix offset).
//   - Each cycle with stall=0: rd_en=1, vec_raddr=vec_start+w, mat_raddr=mat_start+m.
//   - Per issued beat: m+=1, w+=1. When w==N-1: w wraps to 0 and r+=1.
//   - stall=1: rd_en=0, addresses hold, counters hold. The bubble propagates through the pipeline.
//   - The beat with w==N-1 and r==R-1 is the last one; then go to DRAIN.
//   - Address arithmetic is modulo 2^ADDRW; wrap is silent.
//  Tags: first=(w==0), last=(w==N-1), valid=rd_en.
//   - Tags pass through an RD_LAT-stage shift register to accum_first/accum_last/ovalid.
//   - RD_LAT=0 means the tags are coincident with rd_en.
//   - N==1: first and last asserted on the same beat.
//  DRAIN:
//   - Wait until the final tag leaves the pipeline (RD_LAT cycles after the last rd_en).
//   - The cycle after the last ovalid: done=1, busy=0, go to IDLE.
//   - stall is ignored in DRAIN.
//  busy: 1 in ISSUE and DRAIN, 0 otherwise. start while busy is ignored.
//  abort (any non-IDLE state): next cycle state=IDLE, rd_en/ovalid/accum_* 0,
//   pipeline flushed, no done pulse. abort has priority over stall.
//  rst mid-run: same as the reset values above; no done pulse.
//  Back-to-back runs: a start in the cycle done=1 is accepted.
// TESTING (RD_LAT=2 unless stated)
//  1. N=4 R=2 vs=3 ms=10 -> mat_raddr 10..17; vec_raddr 3,4,5,6,3,4,5,6.
//     accum_first on beats 0 and 4, accum_last on beats 3 and 7, each 2 cycles after rd_en.
//     Exactly one done; 8 ovalid beats.
//  2. N=1 R=3 -> 3 beats, each with accum_first=accum_last=1; done after the 3rd ovalid+1.
//  3. Scenario 1 with stall=1 for 3 cycles at beat 2 -> addresses hold, 3-cycle ovalid gap.
//     Sequences are unchanged; done is delayed by 3 cycles.
//  4. abort at beat 5 -> next cycle busy=0 and all outputs 0; no done.
//     A fresh start then runs scenario 1 correctly.
//  5. N=0 (then R=0) -> no rd_en; done 1 cycle after start; busy never 1.
//  6. vs=254 N=4 R=1, ms=510 -> vec_raddr 254,255,0,1; mat_raddr 510,511,0,1.
//     With RD_LAT=0: ovalid coincident with rd_en.

Source files
------------

// File: rtl/mvm_seq_ctrl.sv
// Read-address sequencer for the MVM engine: walks R rows of N words, tags row
// boundaries and delays the tags by the RAM read latency for the MAC lanes.
module mvm_seq_ctrl #(
  parameter int VEC_ADDRW = 8,
  parameter int MAT_ADDRW = 9,
  parameter int VEC_SIZEW = VEC_ADDRW + 1,
  parameter int MAT_SIZEW = MAT_ADDRW + 1,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 stall,
  input  logic [VEC_ADDRW-1:0] vec_start_addr,
  input  logic [VEC_SIZEW-1:0] vec_num_words,
  input  logic [MAT_ADDRW-1:0] mat_start_addr,
  input  logic [MAT_SIZEW-1:0] mat_num_rows_per_olane,
  output logic [VEC_ADDRW-1:0] vec_raddr,
  output logic [MAT_ADDRW-1:0] mat_raddr,
  output logic                 rd_en,
  output logic                 accum_first,
  output logic                 accum_last,
  output logic                 ovalid,
  output logic                 busy,
  output logic                 done
);

  localparam int DCNTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [VEC_ADDRW-1:0] vs_r, vaddr_r;
  logic [MAT_ADDRW-1:0] maddr_r;
  logic [VEC_SIZEW-1:0] w_r, n_m1_r;
  logic [MAT_SIZEW-1:0] r_r, r_m1_r;
  logic [DCNTW-1:0]     dcnt_r;
  logic                 done_r;
  logic                 zero_cfg_s, issue_s, row_end_s, last_beat_s, done_s, flush_s;
  logic [2:0]           tag_s, tag_out_s;

  // Beat qualification and next-state decode.
  always_comb begin
    zero_cfg_s  = (vec_num_words == '0) || (mat_num_rows_per_olane == '0);
    row_end_s   = (w_r == n_m1_r);
    last_beat_s = row_end_s && (r_r == r_m1_r);
    issue_s     = (state_r == S_ISSUE) && !stall && !abort;
    flush_s     = abort && (state_r != S_IDLE);
    tag_s       = {issue_s, issue_s && (w_r == '0), issue_s && row_end_s};
    state_s     = state_r;
    done_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (zero_cfg_s) begin
            done_s = 1'b1;
          end else begin
            state_s = S_ISSUE;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (issue_s && last_beat_s) begin
          // With no read latency the final tag is already out, so finish directly.
          if (RD_LAT == 0) begin
            state_s = S_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = S_DRAIN;
          end
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (dcnt_r == '0) begin
          state_s = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Config latch, address/word/row counters, drain countdown and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_r    <= '0;
      vaddr_r <= '0;
      maddr_r <= '0;
      w_r     <= '0;
      n_m1_r  <= '0;
      r_r     <= '0;
      r_m1_r  <= '0;
      dcnt_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= done_s;
      if (state_r == S_IDLE) begin
        if (start && !zero_cfg_s) begin
          vs_r    <= vec_start_addr;
          vaddr_r <= vec_start_addr;
          maddr_r <= mat_start_addr;
          n_m1_r  <= vec_num_words - VEC_SIZEW'(1);
          r_m1_r  <= mat_num_rows_per_olane - MAT_SIZEW'(1);
          w_r     <= '0;
          r_r     <= '0;
        end
      end else if (abort) begin
        vaddr_r <= '0;
        maddr_r <= '0;
        w_r     <= '0;
        r_r     <= '0;
      end else if (issue_s) begin
        maddr_r <= maddr_r + MAT_ADDRW'(1);
        if (row_end_s) begin
          w_r     <= '0;
          vaddr_r <= vs_r;
          r_r     <= r_r + MAT_SIZEW'(1);
        end else begin
          w_r     <= w_r + VEC_SIZEW'(1);
          vaddr_r <= vaddr_r + VEC_ADDRW'(1);
        end
      end
      // Reloaded every issue cycle so DRAIN always starts from RD_LAT-1.
      if (state_r == S_ISSUE) begin
        dcnt_r <= DCNTW'(RD_LAT - 1);
      end else if (dcnt_r != '0) begin
        dcnt_r <= dcnt_r - DCNTW'(1);
      end
    end
  end

  generate
    if (RD_LAT == 0) begin : g_nolat
      assign tag_out_s = tag_s;
    end else begin : g_lat
      logic [2:0] pipe_r [RD_LAT];
      // Tag delay line matching the RAM read latency; abort drops in-flight beats.
      always_ff @(posedge clk) begin
        if (rst || flush_s) begin
          for (int i = 0; i < RD_LAT; i++) pipe_r[i] <= 3'b000;
        end else begin
          pipe_r[0] <= tag_s;
          for (int i = 1; i < RD_LAT; i++) pipe_r[i] <= pipe_r[i-1];
        end
      end
      assign tag_out_s = pipe_r[RD_LAT-1];
    end
  endgenerate

  assign vec_raddr   = vaddr_r;
  assign mat_raddr   = maddr_r;
  assign rd_en       = issue_s;
  assign ovalid      = tag_out_s[2];
  assign accum_first = tag_out_s[1];
  assign accum_last  = tag_out_s[0];
  assign busy        = (state_r != S_IDLE);
  assign done        = done_r;

endmodule
